// File: rtl/stream_mux_pkg.sv
// Shared types and sizing helpers for the two-source stream mux/arbiter.
package stream_mux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int STAT_W     = 16;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    // Burst counter must represent 0..max_burst inclusive.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with bounded bursts; holds the last grant and run length.
module rr_arb2
    import stream_mux_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic sel
);

    localparam int               CNT_W   = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    src_t             last;
    src_t             grant;
    logic [CNT_W-1:0] cnt;

    // Contention keeps the current owner until its run reaches the burst limit.
    always_comb begin
        grant = last;
        if (req0 && !req1) begin
            grant = SRC0;
        end else if (req1 && !req0) begin
            grant = SRC1;
        end else if (req0 && req1) begin
            grant = (cnt < CNT_MAX) ? last : src_t'(~last);
        end
    end

    assign sel = grant;

    // Reset as "source 1 has just finished a full burst" so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= SRC1;
            cnt  <= CNT_MAX;
        end else if (accept) begin
            last <= grant;
            if (grant == last) begin
                cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
            end else begin
                cnt <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_mux2_arb.sv
// 2:1 valid/ready stream mux with round-robin burst arbitration and a registered output.
// Optional per-source accept counters (stat0/stat1) when STREAM_MUX_STATS_EN is defined.
module stream_mux2_arb
    import stream_mux_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [STAT_W-1:0] stat0,
    output logic [STAT_W-1:0] stat1
`endif
);

    logic free;
    logic accept;

    assign free = !out_valid || out_ready;

    rr_arb2 #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req0  (in0_valid),
        .req1  (in1_valid),
        .accept(accept),
        .sel   (sel)
    );

    assign accept    = free && (sel ? in1_valid : in0_valid);
    assign in0_ready = free && !sel;
    assign in1_ready = free && sel;

    // Output slot: load on accept, empty when drained with nothing new behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= sel ? in1_data : in0_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else if (accept) begin
            if (!sel && (stat0 != '1)) begin
                stat0 <= stat0 + STAT_W'(1);
            end
            if (sel && (stat1 != '1)) begin
                stat1 <= stat1 + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Self-checking bench for stream_mux2_arb: per-cycle reference model plus directed literal checks.
// Exercises the STREAM_MUX_STATS_EN counters when that macro is defined.
module tb_stream_mux2_arb;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in0_data = '0;
    logic              in0_valid = 1'b0;
    logic              in0_ready;
    logic [DATA_W-1:0] in1_data = '0;
    logic              in1_valid = 1'b0;
    logic              in1_ready;
    logic              sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef STREAM_MUX_STATS_EN
    logic [15:0]       stat0;
    logic [15:0]       stat1;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] d0 = '0;
    logic [DATA_W-1:0] d1 = '0;
    logic [DATA_W-1:0] got_q[$];

    stream_mux2_arb #(
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in0_data (in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STREAM_MUX_STATS_EN
        ,
        .stat0    (stat0),
        .stat1    (stat1)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One clock of producer/consumer activity; producers advance their word after a handshake.
    task automatic applyStimulus(input logic v0, input logic v1, input logic ordy);
        logic hs0;
        logic hs1;
        in0_valid = v0;
        in1_valid = v1;
        out_ready = ordy;
        in0_data  = d0;
        in1_data  = d1;
        @(negedge clk);
        hs0 = in0_valid && in0_ready && !rst;
        hs1 = in1_valid && in1_ready && !rst;
        @(posedge clk);
        #1;
        if (hs0) d0 = d0 + 8'd1;
        if (hs1) d1 = d1 + 8'd1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic checkStream(input string name, input logic [DATA_W-1:0] exp[]);
        checkOutput({name, " count"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            checkOutput(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp[i]));
        end
    endtask

    // Reference model: grant history of accepted sources plus the contents of the output slot.
    logic              m_known = 1'b0;
    logic              hist[$];
    logic              m_ov;
    logic [DATA_W-1:0] m_od;
    int                m_s0;
    int                m_s1;

    function automatic int run_len();
        int   n = 0;
        logic l = hist[$];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != l || n == MAX_BURST) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic model_sel(input logic v0, input logic v1);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        if (v0 && v1) return (run_len() < MAX_BURST) ? hist[$] : !hist[$];
        return hist[$];
    endfunction

    initial begin
        logic free;
        logic esel;
        logic acc;
        forever begin
            @(negedge clk);
            if (m_known) begin
                free = !m_ov || out_ready;
                esel = model_sel(in0_valid, in1_valid);
                checkOutput("sel", 32'(sel), 32'(esel));
                checkOutput("in0_ready", 32'(in0_ready), 32'(free && !esel));
                checkOutput("in1_ready", 32'(in1_ready), 32'(free && esel));
                checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
                if (m_ov) checkOutput("out_data", 32'(out_data), 32'(m_od));
`ifdef STREAM_MUX_STATS_EN
                checkOutput("stat0", 32'(stat0), 32'(m_s0));
                checkOutput("stat1", 32'(stat1), 32'(m_s1));
`endif
            end
            if (rst) begin
                hist.delete();
                for (int i = 0; i < MAX_BURST; i++) hist.push_back(1'b1);
                m_ov    = 1'b0;
                m_od    = '0;
                m_s0    = 0;
                m_s1    = 0;
                m_known = 1'b1;
            end else if (m_known) begin
                acc = free && (esel ? in1_valid : in0_valid);
                if (acc) begin
                    hist.push_back(esel);
                    if (hist.size() > MAX_BURST + 1) void'(hist.pop_front());
                    m_od = esel ? in1_data : in0_data;
                    m_ov = 1'b1;
                    if (!esel && m_s0 < 65535) m_s0++;
                    if (esel && m_s1 < 65535) m_s1++;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1 && !rst) got_q.push_back(out_data);
        end
    end

    initial begin
        doReset();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);

        // Reset while a word is stalled in the output slot.
        d1 = 8'h55;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held before reset", 32'(out_data), 32'h55);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        d0 = 8'h11;
        d1 = 8'h91;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("first contention", 32'(out_data), 32'h11);

        // Single source streaming.
        doReset();
        d0 = 8'h10;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("latency out_valid", 32'(out_valid), 32'd1);
        checkOutput("latency out_data", 32'(out_data), 32'h10);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStream("in0 only", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});

        // Continuous contention: bursts of four.
        doReset();
        d0 = 8'h00;
        d1 = 8'h80;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStream("burst", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83, 8'h04, 8'h05});

        // Back-pressure after the first word.
        doReset();
        d0 = 8'hA0;
        d1 = 8'hB0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("stall data", 32'(out_data), 32'hA0);
            checkOutput("stall in0_ready", 32'(in0_ready), 32'd0);
            checkOutput("stall in1_ready", 32'(in1_ready), 32'd0);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStream("backpressure", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4});

        // Long in1 run saturates its burst count, so in0 wins as soon as it joins.
        doReset();
        d0 = 8'h20;
        d1 = 8'h60;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStream("in1 then both", '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                                       8'h20, 8'h21, 8'h22, 8'h23, 8'h66, 8'h67, 8'h68, 8'h69});

`ifdef STREAM_MUX_STATS_EN
        doReset();
        for (int i = 0; i < 150; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stat0 split", 32'(stat0), 32'd150);
        checkOutput("stat1 split", 32'(stat1), 32'd150);
        for (int i = 0; i < 70000; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stat0 saturate", 32'(stat0), 32'h0000FFFF);
        checkOutput("stat1 after saturate", 32'(stat1), 32'd150);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
